// File: rtl/plot_arbiter.sv
// -----------------------------------------------------------------------------
// plot_arbiter
// Two-requester arbiter in front of a vga_adapter plot port.
//   req0 : centroid overlay plots; may lock the port for bursts (req0_lock).
//   req1 : pixel stream plots.
// Granted transfers whose coordinates are inside the X_MAX x Y_MAX screen are
// forwarded one cycle later on vga_*. Out-of-range transfers are accepted but
// dropped and counted in drop_count (saturating, cleared by frame_start).
//
// Build option:
//   ROUND_ROBIN_EN : contention in S_ARB alternates between requesters.
//                    Undefined (default): fixed priority, req0 always wins.
//
// Ports:
//   clock, reset (async, active-high), frame_start (1-cycle frame pulse)
//   req0_valid/lock/x/y/colour -> req0_ready
//   req1_valid/x/y/colour      -> req1_ready
//   vga_plot/x/y/colour        registered plot interface
//   drop_count                 saturating out-of-range transfer count
//   locked                     high while req0 owns the port (S_LOCK0)
// -----------------------------------------------------------------------------
module plot_arbiter #(
   parameter int X_MAX = 320,
   parameter int Y_MAX = 240
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       req0_valid,
   input  logic       req0_lock,
   input  logic [8:0] req0_x,
   input  logic [7:0] req0_y,
   input  logic       req0_colour,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [8:0] req1_x,
   input  logic [7:0] req1_y,
   input  logic       req1_colour,
   output logic       req1_ready,
   output logic       vga_plot,
   output logic [8:0] vga_x,
   output logic [7:0] vga_y,
   output logic       vga_colour,
   output logic [7:0] drop_count,
   output logic       locked
);

   typedef enum logic [0:0] {
      S_ARB   = 1'b0,
      S_LOCK0 = 1'b1
   } state_t;

   // Bounds widened by one bit so a full-range coordinate still compares right.
   localparam logic [9:0] X_LIM = X_MAX[9:0];
   localparam logic [8:0] Y_LIM = Y_MAX[8:0];

   state_t     state_q, state_d;
   logic       locked_q;
   logic       vga_plot_q;
   logic [8:0] vga_x_q;
   logic [7:0] vga_y_q;
   logic       vga_colour_q;
   logic [7:0] drop_q, drop_d;

   logic       xfer0_s, xfer1_s, xfer_s, in_range_s;
   logic [8:0] sel_x_s;
   logic [7:0] sel_y_s;
   logic       sel_colour_s;

`ifdef ROUND_ROBIN_EN
   // High when req1 should win the next contention.
   logic       prio1_q, prio1_d;
`endif

   // Grant generation: ready only ever goes to a requester that is valid.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!reset) begin
         case (state_q)
            S_LOCK0: begin
               req0_ready = req0_valid;
            end
            S_ARB: begin
               if (req0_valid && req1_valid) begin
`ifdef ROUND_ROBIN_EN
                  if (prio1_q) begin
                     req1_ready = 1'b1;
                  end else begin
                     req0_ready = 1'b1;
                  end
`else
                  req0_ready = 1'b1;
`endif
               end else begin
                  req0_ready = req0_valid;
                  req1_ready = req1_valid;
               end
            end
            default: begin
               req0_ready = 1'b0;
               req1_ready = 1'b0;
            end
         endcase
      end else begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
      end
   end

   assign xfer0_s = req0_valid & req0_ready;
   assign xfer1_s = req1_valid & req1_ready;
   assign xfer_s  = xfer0_s | xfer1_s;

   // Transfer payload mux and screen-bounds test.
   always_comb begin
      if (xfer1_s) begin
         sel_x_s      = req1_x;
         sel_y_s      = req1_y;
         sel_colour_s = req1_colour;
      end else begin
         sel_x_s      = req0_x;
         sel_y_s      = req0_y;
         sel_colour_s = req0_colour;
      end
      in_range_s = ({1'b0, sel_x_s} < X_LIM) && ({1'b0, sel_y_s} < Y_LIM);
   end

   // Next state; frame_start deliberately has no influence on the lock.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ARB: begin
            if (xfer0_s && req0_lock) begin
               state_d = S_LOCK0;
            end else begin
               state_d = S_ARB;
            end
         end
         S_LOCK0: begin
            // Release on an unlocked req0 transfer or when req0 goes idle unlocked.
            if (!req0_lock && (xfer0_s || !req0_valid)) begin
               state_d = S_ARB;
            end else begin
               state_d = S_LOCK0;
            end
         end
         default: begin
            state_d = S_ARB;
         end
      endcase
   end

   // Drop counter next value; a frame clear beats a simultaneous drop.
   always_comb begin
      drop_d = drop_q;
      if (frame_start) begin
         drop_d = 8'd0;
      end else if (xfer_s && !in_range_s && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end else begin
         drop_d = drop_q;
      end
   end

   // Arbiter state, plot outputs and drop counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_ARB;
         locked_q     <= 1'b0;
         vga_plot_q   <= 1'b0;
         vga_x_q      <= 9'd0;
         vga_y_q      <= 8'd0;
         vga_colour_q <= 1'b0;
         drop_q       <= 8'd0;
      end else begin
         state_q    <= state_d;
         locked_q   <= (state_d == S_LOCK0);
         vga_plot_q <= xfer_s & in_range_s;
         drop_q     <= drop_d;
         if (xfer_s && in_range_s) begin
            vga_x_q      <= sel_x_s;
            vga_y_q      <= sel_y_s;
            vga_colour_q <= sel_colour_s;
         end
      end
   end

`ifdef ROUND_ROBIN_EN
   // Pointer favours whoever lost the last S_ARB transfer; frame restarts at req0.
   always_comb begin
      prio1_d = prio1_q;
      if (frame_start) begin
         prio1_d = 1'b0;
      end else if ((state_q == S_ARB) && xfer_s) begin
         prio1_d = xfer0_s;
      end else begin
         prio1_d = prio1_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prio1_q <= 1'b0;
      end else begin
         prio1_q <= prio1_d;
      end
   end
`endif

   assign vga_plot   = vga_plot_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign drop_count = drop_q;
   assign locked     = locked_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: each stimulus cycle pushes the expected
// registered outputs; a monitor on the falling edge pops and compares them.
module tb_plot_arbiter;

`ifdef ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   localparam int XM = 320;
   localparam int YM = 240;

   logic       clock = 1'b0;
   logic       reset, frame_start;
   logic       req0_valid, req0_lock, req0_colour, req0_ready;
   logic       req1_valid, req1_colour, req1_ready;
   logic [8:0] req0_x, req1_x, vga_x;
   logic [7:0] req0_y, req1_y, vga_y, drop_count;
   logic       vga_plot, vga_colour, locked;

   always #5 clock = ~clock;

   plot_arbiter #(.X_MAX(XM), .Y_MAX(YM)) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start),
      .req0_valid(req0_valid), .req0_lock(req0_lock), .req0_x(req0_x),
      .req0_y(req0_y), .req0_colour(req0_colour), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y),
      .req1_colour(req1_colour), .req1_ready(req1_ready),
      .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .drop_count(drop_count), .locked(locked)
   );

   typedef struct {
      bit plot;
      int x;
      int y;
      int c;
      int drop;
      bit lk;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: who owns the port, who is favoured, what the screen shows.
   bit m_locked;
   int m_favour;
   int m_vx, m_vy, m_vc, m_drop;
   int dut_grant;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_locked = 1'b0;
      m_favour = 0;
      m_vx = 0; m_vy = 0; m_vc = 0; m_drop = 0;
      sb.delete();
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_lock = 1'b0; req0_x = 9'd0; req0_y = 8'd0; req0_colour = 1'b0;
      req1_valid = 1'b0; req1_x = 9'd0; req1_y = 8'd0; req1_colour = 1'b0;
      frame_start = 1'b0;
   endtask

   // One bus cycle: drive, check grants against the model, predict next outputs.
   task automatic step(input bit v0, input bit l0, input int x0, input int y0, input int c0,
                       input bit v1, input int x1, input int y1, input int c1, input bit fs);
      int   g, gx, gy, gc;
      bit   inr, was_locked;
      exp_t e;
      @(negedge clock);
      req0_valid = v0; req0_lock = l0; req0_x = x0[8:0]; req0_y = y0[7:0]; req0_colour = c0[0];
      req1_valid = v1; req1_x = x1[8:0]; req1_y = y1[7:0]; req1_colour = c1[0];
      frame_start = fs;
      #1;
      if (m_locked)          g = v0 ? 0 : -1;
      else if (v0 && v1)     g = RR ? m_favour : 0;
      else if (v0)           g = 0;
      else if (v1)           g = 1;
      else                   g = -1;
      chk("ready0", {31'd0, req0_ready}, {31'd0, g == 0});
      chk("ready1", {31'd0, req1_ready}, {31'd0, g == 1});
      dut_grant = req0_ready ? 0 : (req1_ready ? 1 : -1);
      gx = (g == 1) ? x1 : x0;
      gy = (g == 1) ? y1 : y0;
      gc = (g == 1) ? c1 : c0;
      inr = (gx < XM) && (gy < YM);
      e.plot = (g >= 0) && inr;
      if (e.plot) begin
         m_vx = gx; m_vy = gy; m_vc = gc;
      end
      if (fs) m_drop = 0;
      else if (g >= 0 && !inr && m_drop < 255) m_drop++;
      was_locked = m_locked;
      if (!was_locked && g == 0 && l0) m_locked = 1'b1;
      else if (was_locked && !l0 && (g == 0 || !v0)) m_locked = 1'b0;
      if (!was_locked && g >= 0) m_favour = 1 - g;
      if (fs) m_favour = 0;
      e.x = m_vx; e.y = m_vy; e.c = m_vc; e.drop = m_drop; e.lk = m_locked;
      sb.push_back(e);
   endtask

   // Monitor: compares the registered outputs produced by the previous cycle.
   always @(negedge clock) begin
      exp_t e;
      if (!reset && sb.size() > 0) begin
         e = sb.pop_front();
         chk("vga_plot", {31'd0, vga_plot}, {31'd0, e.plot});
         chk("vga_x", {23'd0, vga_x}, e.x);
         chk("vga_y", {24'd0, vga_y}, e.y);
         chk("vga_colour", {31'd0, vga_colour}, e.c);
         chk("drop_count", {24'd0, drop_count}, e.drop);
         chk("locked", {31'd0, locked}, {31'd0, e.lk});
      end
   end

   int g24[4];
   int exp24[4];

   initial begin
      idle_inputs();
      reset = 1'b0;
      model_reset();
      #2;
      req0_valid = 1'b1; req1_valid = 1'b1;
      reset = 1'b1;
      #2;
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
      chk("rst_plot", {31'd0, vga_plot}, 32'd0);
      chk("rst_x", {23'd0, vga_x}, 32'd0);
      chk("rst_y", {24'd0, vga_y}, 32'd0);
      chk("rst_drop", {24'd0, drop_count}, 32'd0);
      chk("rst_locked", {31'd0, locked}, 32'd0);
      idle_inputs();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Single requester.
      step(0, 0, 0, 0, 0, 1, 10, 20, 1, 0);
      chk("single_grant", dut_grant, 32'd1);

      // Contention over four cycles.
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 30 + i, 40, 0, 1, 50 + i, 60, 1, 0);
         g24[i] = dut_grant;
      end
      for (int i = 0; i < 4; i++) exp24[i] = RR ? (i % 2) : 0;
      for (int i = 0; i < 4; i++) chk("contention_seq", g24[i], exp24[i]);

      // Lock burst: req1 is held off while req0 owns the port.
      step(1, 1, 5, 5, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         step(0, 1, 0, 0, 0, 1, 7, 7, 1, (i == 1));
         chk("lock_r1_blocked", {31'd0, req1_ready}, 32'd0);
         chk("lock_held", {31'd0, locked}, 32'd1);
      end
      step(1, 0, 6, 6, 0, 1, 7, 7, 1, 0);
      step(0, 0, 0, 0, 0, 1, 8, 8, 1, 0);
      chk("unlock_r1_grant", dut_grant, 32'd1);

      // Bounds.
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1, 320, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0, 240, 1, 0);
      step(0, 0, 0, 0, 0, 1, 319, 239, 1, 0);

      // Saturation then frame clear (also a clear coinciding with a drop).
      for (int i = 0; i < 300; i++)
         step(0, 0, 0, 0, 0, 1, $urandom_range(320, 511), $urandom_range(0, 255), 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("drop_saturated", {24'd0, drop_count}, 32'd255);
      step(0, 0, 0, 0, 0, 1, 400, 10, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("drop_cleared", {24'd0, drop_count}, 32'd0);

      // Randomised traffic.
      for (int i = 0; i < 500; i++)
         step($urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 350),
              $urandom_range(0, 255), $urandom_range(0, 1), ($urandom_range(0, 4) > 1),
              $urandom_range(0, 350), $urandom_range(0, 255), $urandom_range(0, 1),
              ($urandom_range(0, 31) == 0));

      // Reset while locked with a plot on the outputs.
      step(1, 1, 5, 5, 1, 0, 0, 0, 0, 0);
      @(posedge clock);
      #2;
      chk("pre_rst_locked", {31'd0, locked}, 32'd1);
      chk("pre_rst_plot", {31'd0, vga_plot}, 32'd1);
      req1_valid = 1'b1;
      reset = 1'b1;
      #1;
      chk("mid_rst_locked", {31'd0, locked}, 32'd0);
      chk("mid_rst_plot", {31'd0, vga_plot}, 32'd0);
      chk("mid_rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("mid_rst_ready1", {31'd0, req1_ready}, 32'd0);
      model_reset();
      idle_inputs();
      @(negedge clock);
      reset = 1'b0;
      step(0, 0, 0, 0, 0, 1, 11, 12, 0, 0);
      chk("post_rst_r1", {31'd0, req1_ready}, 32'd1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      #1;
      chk("sb_drained", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
